// File: rtl/sync_debounce_pkg.sv
// ============================================================================
// sync_debounce_pkg : shared constants, legality limits and counter width
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_debounce_pkg;

  localparam int N_CH_DEFAULT          = 1;
  localparam int SYNC_STAGES_DEFAULT   = 2;
  localparam int STABLE_CYCLES_DEFAULT = 4;

  localparam int N_CH_MIN          = 1;
  localparam int N_CH_MAX          = 32;
  localparam int SYNC_STAGES_MIN   = 2;
  localparam int STABLE_CYCLES_MIN = 1;

  // Counter only needs to reach STABLE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce_if.sv
// ============================================================================
// sync_debounce_if : raw inputs, tick enable and debounced outputs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_debounce_if #(
  parameter int N_CH = 1
);

  logic [N_CH-1:0] din;
  logic            tick;
  logic [N_CH-1:0] dout;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  modport master (
    output din,
    output tick,
    input  dout,
    input  rise,
    input  fall
  );

  modport slave (
    input  din,
    input  tick,
    output dout,
    output rise,
    output fall
  );

endinterface

`default_nettype wire

// File: rtl/sync_debounce_channel.sv
// ============================================================================
// debounce_channel : one-bit synchronizer, persistence counter, edge pulses
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int   STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter logic INIT_LEVEL    = 1'b0
)(
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic tick,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW         = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   w_sync_q;

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Any return to agreement with dout throws the partial count away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      dout  <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (w_sync_q == dout) begin
        r_cnt <= '0;
      end else if (tick) begin
        if (r_cnt == C_CNT_LAST) begin
          r_cnt <= '0;
          dout  <= w_sync_q;
          rise  <= w_sync_q;
          fall  <= ~w_sync_q;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_debounce.sv
// ============================================================================
// sync_debounce : N_CH independent synchronise-and-debounce channels
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int              N_CH          = N_CH_DEFAULT,
  parameter int              SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int              STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter logic [N_CH-1:0] INIT_LEVEL    = '0
)(
  input logic            clk,
  input logic            rst,
  sync_debounce_if.slave bus
);

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
    $error("sync_debounce: N_CH=%0d outside %0d..%0d", N_CH, N_CH_MIN, N_CH_MAX);
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $error("sync_debounce: SYNC_STAGES=%0d below %0d", SYNC_STAGES, SYNC_STAGES_MIN);
  end
  if (STABLE_CYCLES < STABLE_CYCLES_MIN) begin : g_bad_stable_cycles
    $error("sync_debounce: STABLE_CYCLES=%0d below %0d", STABLE_CYCLES, STABLE_CYCLES_MIN);
  end

  logic [N_CH-1:0] w_dout;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .INIT_LEVEL    (INIT_LEVEL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.din[i]),
      .tick (bus.tick),
      .dout (w_dout[i]),
      .rise (w_rise[i]),
      .fall (w_fall[i])
    );
  end

  assign bus.dout = w_dout;
  assign bus.rise = w_rise;
  assign bus.fall = w_fall;

endmodule

`default_nettype wire

// File: tb/tb_sync_debounce.sv
// ============================================================================
// tb_sync_debounce : directed + randomized bench against a persistence model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_debounce;

  localparam int         N    = 4;
  localparam int         S    = 2;
  localparam int         ST   = 8;
  localparam logic [3:0] INIT = 4'b1000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  sync_debounce_if #(.N_CH(N)) bus ();

  sync_debounce #(
    .N_CH          (N),
    .SYNC_STAGES   (S),
    .STABLE_CYCLES (ST),
    .INIT_LEVEL    (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: din delayed by S samples, a level is accepted once it has differed
  // from dout for ST ticked edges in an unbroken stretch.
  logic [3:0] m_hist [$];
  int         m_run  [N];
  logic [3:0] m_dout, m_rise, m_fall;
  logic [3:0] cur_din;

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i < S; i++) m_hist.push_back(INIT);
    for (int c = 0; c < N; c++) m_run[c] = 0;
    m_dout = INIT;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge(input logic [3:0] d, input logic t);
    logic [3:0] sq;
    logic [3:0] prev;
    sq   = m_hist[S-1];
    prev = m_dout;
    for (int c = 0; c < N; c++) begin
      if (sq[c] == m_dout[c]) m_run[c] = 0;
      else if (t) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == ST) begin
          m_dout[c] = sq[c];
          m_run[c]  = 0;
        end
      end
    end
    m_rise = m_dout & ~prev;
    m_fall = ~m_dout & prev;
    m_hist.push_front(d);
    void'(m_hist.pop_back());
  endtask

  // Drive on the falling edge, advance the model on the rising edge, then
  // leave the caller 1 time unit past the edge to sample.
  task automatic cycle(input logic [3:0] d, input logic t, input logic r);
    @(negedge clk);
    bus.din  = d;
    bus.tick = t;
    rst      = r;
    cur_din  = d;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(d, t);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0111, 1'b1, 1'b1);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {INIT, 4'b0, 4'b0}) begin
        n_fail++;
        $display("FAIL reset_hold dout/rise/fall=%b/%b/%b expected %b/0000/0000",
                 bus.dout, bus.rise, bus.fall, INIT);
      end
    end
    cycle(INIT, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.dout, bus.rise, bus.fall} !== {INIT, 4'b0, 4'b0}) begin
      n_fail++;
      $display("FAIL reset_release dout/rise/fall=%b/%b/%b expected %b/0000/0000",
               bus.dout, bus.rise, bus.fall, INIT);
    end
    for (int k = 0; k < 4; k++) cycle(INIT, 1'b1, 1'b0);
  endtask

  task automatic test_step();
    int first_k;
    int n_rise;
    first_k = -1;
    n_rise  = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(4'b1001, 1'b1, 1'b0);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL step_model dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      if (bus.rise[0] === 1'b1) begin
        n_rise++;
        if (first_k < 0) first_k = k;
      end
    end
    n_cmp++;
    if (first_k != S + ST) begin
      n_fail++;
      $display("FAIL step_latency rise at edge %0d expected %0d", first_k, S + ST);
    end
    n_cmp++;
    if (n_rise != 1 || bus.dout[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL step_pulse rise_count=%0d dout0=%b expected 1/1", n_rise, bus.dout[0]);
    end
  endtask

  task automatic test_glitch();
    int n_ev;
    int fall_k;
    int n_rise;
    n_ev = 0;
    for (int k = 0; k < 22; k++) begin
      cycle((k < 7) ? 4'b1011 : 4'b1001, 1'b1, 1'b0);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL glitch_model dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      if (bus.dout[1] !== 1'b0 || bus.rise[1] !== 1'b0 || bus.fall[1] !== 1'b0) n_ev++;
    end
    n_cmp++;
    if (n_ev != 0) begin
      n_fail++;
      $display("FAIL glitch_7 ch1 activity cycles=%0d expected 0", n_ev);
    end
    fall_k = -1;
    n_rise = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1011, 1'b1, 1'b0);
      if (bus.rise[1] === 1'b1) n_rise++;
    end
    for (int k = 1; k <= 30; k++) begin
      cycle(4'b1001, 1'b1, 1'b0);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL glitch8_model dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      if (bus.rise[1] === 1'b1) n_rise++;
      if (bus.fall[1] === 1'b1 && fall_k < 0) fall_k = k;
    end
    n_cmp++;
    if (n_rise != 1) begin
      n_fail++;
      $display("FAIL glitch_8_rise rise_count=%0d expected 1", n_rise);
    end
    n_cmp++;
    if (fall_k != S + ST) begin
      n_fail++;
      $display("FAIL glitch_8_fall fall at edge %0d expected %0d", fall_k, S + ST);
    end
  endtask

  task automatic test_toggle();
    int n_rise;
    int n_fall;
    int rise_k;
    logic [3:0] d;
    n_rise = 0;
    n_fall = 0;
    rise_k = -1;
    for (int k = 0; k < 30; k++) begin
      d = 4'b1001;
      d[2] = (((k / 3) % 2) == 0);
      cycle(d, 1'b1, 1'b0);
      if (bus.rise[2] === 1'b1) n_rise++;
      if (bus.fall[2] === 1'b1) n_fall++;
    end
    for (int k = 1; k <= 20; k++) begin
      cycle(4'b1101, 1'b1, 1'b0);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL toggle_model dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      if (bus.rise[2] === 1'b1) begin
        n_rise++;
        if (rise_k < 0) rise_k = k;
      end
      if (bus.fall[2] === 1'b1) n_fall++;
    end
    n_cmp++;
    if (n_rise != 1 || n_fall != 0 || rise_k != S + ST) begin
      n_fail++;
      $display("FAIL toggle_pulses rise=%0d fall=%0d at=%0d expected 1/0/%0d",
               n_rise, n_fall, rise_k, S + ST);
    end
  endtask

  task automatic test_simul();
    int hit_k;
    int n_other;
    hit_k   = -1;
    n_other = 0;
    cycle(INIT, 1'b1, 1'b1);
    cycle(INIT, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cycle(4'b0100, 1'b1, 1'b0);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL simul_model dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      if (bus.rise[2] === 1'b1 && bus.fall[3] === 1'b1 && hit_k < 0) hit_k = k;
      if ((bus.rise ^ bus.fall) !== 4'b0000 && !(bus.rise === 4'b0100 && bus.fall === 4'b1000))
        n_other++;
    end
    n_cmp++;
    if (hit_k != S + ST || n_other != 0) begin
      n_fail++;
      $display("FAIL simul_pulses joint pulse at %0d stray=%0d expected %0d/0",
               hit_k, n_other, S + ST);
    end
  endtask

  task automatic test_tick();
    int ev_k;
    // Tick on every 4th clock starting with the capturing edge: the 8th tick
    // that sees a mismatched sync_q lands on edge 32.
    for (int k = 0; k < 15; k++) cycle(4'b1001, 1'b1, 1'b0);
    ev_k = -1;
    for (int k = 0; k < 40; k++) begin
      cycle(4'b1000, (k % 4) == 0, 1'b0);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL tick_model dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      if (bus.fall[0] === 1'b1 && ev_k < 0) ev_k = k;
    end
    n_cmp++;
    if (ev_k != 32) begin
      n_fail++;
      $display("FAIL tick_fall fall at edge %0d expected 32", ev_k);
    end
    for (int k = 0; k < 15; k++) cycle(4'b1001, 1'b1, 1'b0);
    for (int k = 0; k <= 20; k++) cycle(4'b1000, (k % 4) == 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cycle(4'b1000, 1'b1, 1'b1);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {INIT, 4'b0, 4'b0}) begin
        n_fail++;
        $display("FAIL tick_reset dout/rise/fall=%b/%b/%b expected %b/0000/0000",
                 bus.dout, bus.rise, bus.fall, INIT);
      end
    end
    ev_k = -1;
    for (int k = 0; k < 40; k++) begin
      cycle(4'b0001, (k % 4) == 0, 1'b0);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL tick_restart_model dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      if (bus.rise[0] === 1'b1 && bus.fall[3] === 1'b1 && ev_k < 0) ev_k = k;
    end
    n_cmp++;
    if (ev_k != 32) begin
      n_fail++;
      $display("FAIL tick_restart edge %0d expected 32", ev_k);
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic       t;
    logic       r;
    int         rst_left;
    rst_left = 0;
    d = cur_din;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(11, 0) == 0) d[c] = ~d[c];
      t = ($urandom_range(3, 0) != 0);
      if (rst_left == 0 && $urandom_range(299, 0) == 0) rst_left = $urandom_range(2, 1);
      r = (rst_left != 0);
      if (rst_left != 0) rst_left--;
      cycle(d, t, r);
      n_cmp++;
      if ({bus.dout, bus.rise, bus.fall} !== {m_dout, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL random_model k=%0d dout/rise/fall=%b/%b/%b expected %b/%b/%b",
                 k, bus.dout, bus.rise, bus.fall, m_dout, m_rise, m_fall);
      end
      n_cmp++;
      if ((bus.rise & bus.fall) !== 4'b0000) begin
        n_fail++;
        $display("FAIL random_rise_fall_overlap k=%0d rise&fall=%b expected 0000",
                 k, bus.rise & bus.fall);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.din  = INIT;
    bus.tick = 1'b1;
    cur_din  = INIT;
    model_reset();
    test_reset();
    test_step();
    test_glitch();
    test_toggle();
    test_simul();
    test_tick();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
